mod_counter_n: RTL and testbench
================================

MOD_COUNTER_N -- requirements
Module: mod_counter_n

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the counter width in bits.
REQ-002 The block SHALL have parameter MODULO, default 12, giving the count range 0..MODULO-1.
REQ-003 The block SHALL have parameter PRESCALE, default 1, giving the valid_count cycles per count step; it is used only with MODCNT_PRESCALE_EN.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port valid_count, input, 1 bit: count enable; when low, the count holds.
REQ-007 The block SHALL have port dir, input, 1 bit: 1 = count up, 0 = count down.
REQ-008 The block SHALL have port clr, input, 1 bit: synchronous clear to 0.
REQ-009 The block SHALL have port load, input, 1 bit: synchronous load of load_val.
REQ-010 The block SHALL have port load_val, input, WIDTH bits: value to load.
REQ-011 The block SHALL have port out, output reg, WIDTH bits: current count.
REQ-012 The block SHALL have port wrap, output reg, 1 bit: one-cycle pulse when the count wraps.
REQ-013 The block SHALL have port load_err, output reg, 1 bit: sticky flag set by an out-of-range load.

Function
REQ-014 Per-cycle priority SHALL be: clr, then load, then count step, then hold.
REQ-015 Up step SHALL be: out==MODULO-1 -> 0 with wrap=1; otherwise out+1.
REQ-016 Down step SHALL be: out==0 -> MODULO-1 with wrap=1; otherwise out-1.
REQ-017 wrap SHALL be registered, high for exactly the one cycle in which out shows the wrapped value, and 0 in every other cycle, including hold, clr and load cycles.
REQ-018 valid_count=0 with clr=0 and load=0 SHALL hold out unchanged.
REQ-019 clr=1 SHALL set out=0, wrap=0 and load_err=0 on the next edge, regardless of load and valid_count.
REQ-020 load=1 with load_val<MODULO SHALL set out=load_val on the next edge, with no count step in that cycle.
REQ-021 load=1 with load_val>=MODULO SHALL set out=MODULO-1 and set load_err=1; load_err stays set until clr or reset.
REQ-022 A dir change SHALL take effect on the same edge it is sampled; there is no pipeline.
REQ-023 Arithmetic SHALL be WIDTH bits wide, and out SHALL never leave 0..MODULO-1 in any cycle.
REQ-024 Elaboration SHALL fail unless 2<=MODULO<=2**WIDTH and PRESCALE>=1.

Reset
REQ-025 rst_n low SHALL immediately force out=0, wrap=0, load_err=0 and the prescaler count to 0, independent of clk.
REQ-026 Reset in the middle of a count or wrap SHALL discard the in-flight step; counting resumes from 0 on the first edge after rst_n goes high.

Configuration
REQ-027 Macro MODCNT_PRESCALE_EN defined: a count step SHALL occur only on every PRESCALE-th cycle with valid_count=1 (and clr=0, load=0).
REQ-028 Under MODCNT_PRESCALE_EN, clr, load and reset SHALL zero the prescaler count; valid_count=0 SHALL hold it.
REQ-029 Macro MODCNT_PRESCALE_EN undefined: every qualified valid_count cycle SHALL step, PRESCALE SHALL be ignored, and no prescaler logic SHALL be generated.

Structure
REQ-030 Shared package mod_counter_pkg SHALL hold the direction constants DIR_UP=1 and DIR_DN=0 and the default WIDTH/MODULO constants.
REQ-031 The prescaler SHALL be the sub-module modcnt_prescaler, with ports clk, rst_n, en, restart and tick, instantiated only under MODCNT_PRESCALE_EN.

Verification (WIDTH=4, MODULO=12 unless stated)
REQ-032 Reset, then dir=1 and valid_count=1 for 13 cycles -> out 1..11, 0, 1; wrap high only in the cycle out=0.
REQ-033 Down count from out=0 with dir=0 -> out=11 and wrap=1 for one cycle; hold with valid_count=0 for 3 cycles -> out=11 and wrap=0.
REQ-034 load=1 with load_val=14 -> out=11 and load_err=1; load_err stays 1 until clr=1, then out=0 and load_err=0.
REQ-035 clr, load and valid_count all high with load_val=5 -> out=0; rst_n pulsed low mid-cycle at out=7 -> out=0 before the next edge.
REQ-036 MODCNT_PRESCALE_EN with PRESCALE=3 and valid_count held high for 9 cycles -> out steps 0->1->2->3, one step per 3 cycles.
REQ-037 WIDTH=8 with MODULO=256 and with MODULO=200 -> out wraps 255->0 and 199->0 respectively, with one wrap pulse each.

Source files
------------

// File: rtl/mod_counter_pkg.sv
// Shared constants for the modulo-N up/down counter: direction encodings and default geometry.
package mod_counter_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  localparam int unsigned DEF_WIDTH  = 4;
  localparam int unsigned DEF_MODULO = 12;

endpackage

// File: rtl/modcnt_prescaler.sv
// Divides qualified enable cycles by PRESCALE; tick marks the enable cycle that completes a group.
// Only compiled when MODCNT_PRESCALE_EN is defined.
`ifdef MODCNT_PRESCALE_EN
module modcnt_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(PRESCALE - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == CntLast);

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`endif

// File: rtl/mod_counter_n.sv
// Modulo-MODULO up/down counter with clear, range-checked load and a one-cycle wrap pulse.
// Define MODCNT_PRESCALE_EN to step only on every PRESCALE-th qualified valid_count cycle.
module mod_counter_n
  import mod_counter_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned MODULO   = DEF_MODULO,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_count,
  input  logic             dir,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             wrap,
  output logic             load_err
);

  if (MODULO < 2 || 64'(MODULO) > (64'd1 << WIDTH) || PRESCALE < 1) begin : gen_bad_cfg
    $error("mod_counter_n: need 2 <= MODULO <= 2**WIDTH and PRESCALE >= 1");
  end

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULO - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic             step;

`ifdef MODCNT_PRESCALE_EN
  logic step_en;
  logic restart;

  assign step_en = valid_count & ~clr & ~load;
  assign restart = clr | load;

  modcnt_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (step_en),
    .restart(restart),
    .tick   (step)
  );
`else
  assign step = valid_count;
`endif

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    err_d   = err_q;
    if (clr) begin
      count_d = '0;
      err_d   = 1'b0;
    end else if (load) begin
      // Out-of-range loads saturate so out never leaves 0..MODULO-1.
      if (load_val > MaxVal) begin
        count_d = MaxVal;
        err_d   = 1'b1;
      end else begin
        count_d = load_val;
      end
    end else if (step) begin
      if (dir == DIR_UP) begin
        if (count_q == MaxVal) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (count_q == '0) begin
          count_d = MaxVal;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign out      = count_q;
  assign wrap     = wrap_q;
  assign load_err = err_q;

endmodule

// File: tb/tb_mod_counter_n.sv
// Directed self-checking bench for mod_counter_n (WIDTH=4/MODULO=12, plus 8-bit wrap instances).
module tb_mod_counter_n;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid_count, dir, clr, load;
  logic [3:0] load_val;
  logic [3:0] out;
  logic       wrap, load_err;

  // 8-bit instances share control; separate load values.
  logic       valid8, load8;
  logic [7:0] lv8a, lv8b;
  logic [7:0] out8a, out8b;
  logic       wrap8a, wrap8b, err8a, err8b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mod_counter_n #(.WIDTH(4), .MODULO(12), .PRESCALE(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_count(valid_count),
    .dir        (dir),
    .clr        (clr),
    .load       (load),
    .load_val   (load_val),
    .out        (out),
    .wrap       (wrap),
    .load_err   (load_err)
  );

  mod_counter_n #(.WIDTH(8), .MODULO(256), .PRESCALE(1)) dut8a (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_count(valid8),
    .dir        (1'b1),
    .clr        (1'b0),
    .load       (load8),
    .load_val   (lv8a),
    .out        (out8a),
    .wrap       (wrap8a),
    .load_err   (err8a)
  );

  mod_counter_n #(.WIDTH(8), .MODULO(200), .PRESCALE(1)) dut8b (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_count(valid8),
    .dir        (1'b1),
    .clr        (1'b0),
    .load       (load8),
    .load_val   (lv8b),
    .out        (out8b),
    .wrap       (wrap8b),
    .load_err   (err8b)
  );

`ifdef MODCNT_PRESCALE_EN
  logic       validp, clrp;
  logic [3:0] outp;
  logic       wrapp, errp;

  mod_counter_n #(.WIDTH(4), .MODULO(12), .PRESCALE(3)) dut_p (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_count(validp),
    .dir        (1'b1),
    .clr        (clrp),
    .load       (1'b0),
    .load_val   (4'd0),
    .out        (outp),
    .wrap       (wrapp),
    .load_err   (errp)
  );
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_main(input string tag, input int e_out, input int e_wrap, input int e_err);
    check({tag, ".out"}, 32'(out), 32'(e_out));
    check({tag, ".wrap"}, 32'(wrap), 32'(e_wrap));
    check({tag, ".load_err"}, 32'(load_err), 32'(e_err));
  endtask

  initial begin
    rst_n = 1'b0; valid_count = 1'b0; dir = 1'b1; clr = 1'b0; load = 1'b0; load_val = '0;
    valid8 = 1'b0; load8 = 1'b0; lv8a = '0; lv8b = '0;
`ifdef MODCNT_PRESCALE_EN
    validp = 1'b0; clrp = 1'b0;
`endif
    #12;
    check_main("reset", 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Up count through the wrap.
    dir = 1'b1; valid_count = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      step();
      check_main($sformatf("up%0d", i), i % 12, (i == 12) ? 1 : 0, 0);
    end

    // Hold.
    valid_count = 1'b0;
    step(); check_main("hold_up", 1, 0, 0);

    // Clear, then down-wrap from 0 and hold.
    clr = 1'b1; step(); check_main("clr0", 0, 0, 0);
    clr = 1'b0; dir = 1'b0; valid_count = 1'b1;
    step(); check_main("dn_wrap", 11, 1, 0);
    valid_count = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); check_main($sformatf("dn_hold%0d", i), 11, 0, 0);
    end
    valid_count = 1'b1;
    step(); check_main("dn_step", 10, 0, 0);
    valid_count = 1'b0;

    // Out-of-range load saturates, error sticks until clear.
    load = 1'b1; load_val = 4'd14;
    step(); check_main("load14", 11, 0, 1);
    load_val = 4'd3;
    step(); check_main("load3_sticky", 3, 0, 1);
    load = 1'b0; dir = 1'b1; valid_count = 1'b1;
    step(); check_main("up_sticky", 4, 0, 1);
    valid_count = 1'b0; clr = 1'b1;
    step(); check_main("clr_err", 0, 0, 0);
    clr = 1'b0;

    // In-range load wins over count step; then count up into wrap.
    load = 1'b1; load_val = 4'd9; valid_count = 1'b1; dir = 1'b1;
    step(); check_main("load9", 9, 0, 0);
    load = 1'b0;
    step(); check_main("up10", 10, 0, 0);
    step(); check_main("up11", 11, 0, 0);
    step(); check_main("up_wrap", 0, 1, 0);
    valid_count = 1'b0;

    // load_val == MODULO boundary.
    load = 1'b1; load_val = 4'd12;
    step(); check_main("load12", 11, 0, 1);

    // clr beats load and valid_count.
    clr = 1'b1; load = 1'b1; load_val = 4'd5; valid_count = 1'b1;
    step(); check_main("clr_prio", 0, 0, 0);
    clr = 1'b0; valid_count = 1'b0; load_val = 4'd7;
    step(); check_main("load7", 7, 0, 0);
    load = 1'b0; valid_count = 1'b1; dir = 1'b1;

    // Asynchronous reset mid-cycle.
    #3 rst_n = 1'b0;
    #1 check_main("async_rst", 0, 0, 0);
    #1 rst_n = 1'b1;
    step(); check_main("post_rst", 1, 0, 0);

    // Direction change takes effect on the same edge.
    dir = 1'b0;
    step(); check_main("dir_dn0", 0, 0, 0);
    step(); check_main("dir_dn_wrap", 11, 1, 0);
    valid_count = 1'b0;

    // 8-bit wraps at 256 and 200.
    load8 = 1'b1; lv8a = 8'd254; lv8b = 8'd198;
    step();
    check("w8a.load", 32'(out8a), 32'd254);
    check("w8b.load", 32'(out8b), 32'd198);
    load8 = 1'b0; valid8 = 1'b1;
    step();
    check("w8a.max", 32'(out8a), 32'd255);
    check("w8b.max", 32'(out8b), 32'd199);
    check("w8a.wrap_pre", 32'(wrap8a), 32'd0);
    check("w8b.wrap_pre", 32'(wrap8b), 32'd0);
    step();
    check("w8a.wrapval", 32'(out8a), 32'd0);
    check("w8b.wrapval", 32'(out8b), 32'd0);
    check("w8a.wrap", 32'(wrap8a), 32'd1);
    check("w8b.wrap", 32'(wrap8b), 32'd1);
    step();
    check("w8a.after", 32'(out8a), 32'd1);
    check("w8b.after", 32'(out8b), 32'd1);
    check("w8a.wrap_post", 32'(wrap8a), 32'd0);
    check("w8b.wrap_post", 32'(wrap8b), 32'd0);
    check("w8b.err", 32'(err8b), 32'd0);
    valid8 = 1'b0;

`ifdef MODCNT_PRESCALE_EN
    clrp = 1'b1; step();
    check("psc.clr", 32'(outp), 32'd0);
    clrp = 1'b0; validp = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      step();
      check($sformatf("psc%0d", i), 32'(outp), 32'(i / 3));
    end
    validp = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
